alu_issue_ctrl: RTL and testbench
=================================

Name: alu_issue_ctrl

Overview:
- Initiator side of the datapath ALU interface. Accepts operation commands over a valid/ready handshake and translates the opcode to the ALU's one-hot op code.
- Drives the ALU operand and op lines, holds them for a programmable number of cycles, then samples result/eq into a response register.
- Returns the response over a second valid/ready handshake. Sits between the multicycle controller/register file and the combinational ALU.

Parameters:
- DATA_W, 16, operand/result width; must match ALU width.
- EXEC_CYCLES, 1, cycles alu_op is held before sampling; legal 1..15.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  block can accept a command.
- cmd_opcode  in  3  0 MOV, 1 ADD, 2 SUB, 3 AND, 4 OR, 5 NOT, 6 CMP, 7 illegal.
- cmd_a  in  DATA_W  operand i.
- cmd_b  in  DATA_W  operand j.
- alu_data_i  out  DATA_W  to ALU operand i.
- alu_data_j  out  DATA_W  to ALU operand j.
- alu_op  out  7  one-hot ALU op code.
- alu_result  in  DATA_W  from ALU.
- alu_eq  in  1  from ALU.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer takes response.
- rsp_data  out  DATA_W  captured result.
- rsp_eq  out  1  captured compare flag.
- rsp_err  out  1  illegal opcode flag.

Behaviour:
- States: IDLE, EXEC, RESP. Reset to IDLE; alu_data_i/j, alu_op, rsp_data, rsp_eq, rsp_err, rsp_valid all 0; exec counter 0.
- cmd_ready = (state==IDLE), decoded from the state register. A command presented while rst is high is ignored.
- IDLE: on cmd_valid&&cmd_ready, register cmd_a, cmd_b and the opcode.
  - Legal opcode: go to EXEC and load the counter with EXEC_CYCLES-1.
  - Opcode 7: skip EXEC, go straight to RESP with rsp_err=1, rsp_data=0, rsp_eq=0. The ALU sees no op.
- Opcode mapping for alu_op: MOV 0000001, ADD 0000010, SUB 0000100, AND 0001000, OR 0010000, NOT 0100000, CMP 1000111.
- alu_op is nonzero only in EXEC. It is 0000000 in IDLE and RESP.
- alu_data_i/j hold the last accepted operands until the next accept.
- EXEC: the counter decrements each cycle. When it reaches 0, capture on that edge and go to RESP:
  - Non-CMP: rsp_data = alu_result, rsp_eq = 0.
  - CMP: rsp_eq = alu_eq, rsp_data = 0. ALU result is not valid for CMP.
  - rsp_err = 0.
- Latency, EXEC_CYCLES=1: accept at edge T, EXEC during T..T+1, rsp_valid high after edge T+1.
- RESP: rsp_valid=1. rsp_data/eq/err are stable while rsp_valid && !rsp_ready. On rsp_ready, go to IDLE and drop rsp_valid on the same edge.
- Commands never overlap. Best-case throughput is one op per 3 cycles; the next command can be accepted the cycle after the response is taken.
- rsp_ready held high before RESP has no effect. The response is never dropped.
- Widths: no arithmetic in this block. Operands pass through unmodified, DATA_W bits.
- rst asserted mid-EXEC or mid-RESP: the next edge returns to IDLE with all outputs zeroed. The pending response is discarded.

Optional Feature:
- Macro ALU_ISSUE_STATS_EN.
- Defined: adds outputs stat_ops (16 bits), a count of responses handed off with rsp_err=0, and stat_err (8 bits), a count of responses handed off with rsp_err=1.
  - Both increment on the rsp_valid&&rsp_ready edge.
  - Both saturate at all-ones and clear on rst.
- Undefined: ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset then ADD: cmd_a=0x0003, cmd_b=0x0004, opcode 1 -> alu_op=0000010 for 1 cycle; rsp_valid 2 edges after accept; rsp_data=0x0007, rsp_eq=0, rsp_err=0.
- SUB wrap: a=0x0000, b=0x0001 -> rsp_data=0xFFFF. NOT: b=0x0000 -> rsp_data per ALU (0x0001).
- CMP: a=b=0x1234 -> alu_op=1000111, rsp_eq=1, rsp_data=0. Then a=0x1234, b=0x1235 -> rsp_eq=0.
- Illegal opcode 7 -> alu_op stays 0; rsp_err=1, rsp_data=0, rsp_eq=0 one edge after accept.
- Backpressure: hold rsp_ready=0 for 5 cycles -> rsp_valid and rsp_data stable, cmd_ready=0. Release -> IDLE, next command accepted on the following cycle.
- EXEC_CYCLES=3 with mid-EXEC rst pulse -> alu_op held 3 cycles when not reset. With reset: outputs zero next edge, no response, cmd_ready=1 after reset.
- With ALU_ISSUE_STATS_EN: 3 legal ops + 1 illegal -> stat_ops=3, stat_err=1.

Source files
------------

// File: rtl/alu_issue_ctrl_if.sv
// Bundle of command, response and ALU-side signals for alu_issue_ctrl.
// slave is the issue controller's view; master is the view of its surroundings.
interface alu_issue_ctrl_if #(
  parameter int DATA_W = 16
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [2:0]        cmd_opcode;
  logic [DATA_W-1:0] cmd_a;
  logic [DATA_W-1:0] cmd_b;

  logic [DATA_W-1:0] alu_data_i;
  logic [DATA_W-1:0] alu_data_j;
  logic [6:0]        alu_op;
  logic [DATA_W-1:0] alu_result;
  logic              alu_eq;

  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_data;
  logic              rsp_eq;
  logic              rsp_err;

  modport slave (
    input  cmd_valid, cmd_opcode, cmd_a, cmd_b, alu_result, alu_eq, rsp_ready,
    output cmd_ready, alu_data_i, alu_data_j, alu_op, rsp_valid, rsp_data, rsp_eq, rsp_err
  );

  modport master (
    output cmd_valid, cmd_opcode, cmd_a, cmd_b, alu_result, alu_eq, rsp_ready,
    input  cmd_ready, alu_data_i, alu_data_j, alu_op, rsp_valid, rsp_data, rsp_eq, rsp_err
  );
endinterface

// File: rtl/alu_issue_ctrl.sv
// Issues one command at a time to a combinational ALU, holds it EXEC_CYCLES cycles, returns the result.
// Optional macro ALU_ISSUE_STATS_EN adds saturating handoff counters stat_ops / stat_err.
module alu_issue_ctrl #(
  parameter int DATA_W      = 16,
  parameter int EXEC_CYCLES = 1
) (
  input  logic clk,
  input  logic rst,
  alu_issue_ctrl_if.slave bus
`ifdef ALU_ISSUE_STATS_EN
  ,
  output logic [15:0] stat_ops,
  output logic [7:0]  stat_err
`endif
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_e;

  localparam logic [3:0] CntLoad   = 4'(EXEC_CYCLES - 1);
  localparam logic [2:0] OpcCmp    = 3'd6;
  localparam logic [2:0] OpcIllegal = 3'd7;

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [2:0]        opcode_q, opcode_d;
  logic [DATA_W-1:0] aluDataI_q, aluDataI_d;
  logic [DATA_W-1:0] aluDataJ_q, aluDataJ_d;
  logic [DATA_W-1:0] rspData_q, rspData_d;
  logic              rspEq_q, rspEq_d;
  logic              rspErr_q, rspErr_d;
  logic [6:0]        aluOp;

  // The ALU only ever sees an op while a legal command is executing.
  always_comb begin
    aluOp = 7'b0000000;
    if (state_q == EXEC) begin
      case (opcode_q)
        3'd0:    aluOp = 7'b0000001;
        3'd1:    aluOp = 7'b0000010;
        3'd2:    aluOp = 7'b0000100;
        3'd3:    aluOp = 7'b0001000;
        3'd4:    aluOp = 7'b0010000;
        3'd5:    aluOp = 7'b0100000;
        3'd6:    aluOp = 7'b1000111;
        default: aluOp = 7'b0000000;
      endcase
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    opcode_d   = opcode_q;
    aluDataI_d = aluDataI_q;
    aluDataJ_d = aluDataJ_q;
    rspData_d  = rspData_q;
    rspEq_d    = rspEq_q;
    rspErr_d   = rspErr_q;
    case (state_q)
      IDLE: begin
        if (bus.cmd_valid) begin
          aluDataI_d = bus.cmd_a;
          aluDataJ_d = bus.cmd_b;
          opcode_d   = bus.cmd_opcode;
          if (bus.cmd_opcode == OpcIllegal) begin
            state_d   = RESP;
            rspData_d = '0;
            rspEq_d   = 1'b0;
            rspErr_d  = 1'b1;
          end else begin
            state_d = EXEC;
            cnt_d   = CntLoad;
          end
        end
      end
      EXEC: begin
        if (cnt_q == 4'd0) begin
          state_d  = RESP;
          rspErr_d = 1'b0;
          // The ALU result bus carries nothing meaningful for a compare.
          if (opcode_q == OpcCmp) begin
            rspData_d = '0;
            rspEq_d   = bus.alu_eq;
          end else begin
            rspData_d = bus.alu_result;
            rspEq_d   = 1'b0;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        if (bus.rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      opcode_q   <= '0;
      aluDataI_q <= '0;
      aluDataJ_q <= '0;
      rspData_q  <= '0;
      rspEq_q    <= 1'b0;
      rspErr_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      opcode_q   <= opcode_d;
      aluDataI_q <= aluDataI_d;
      aluDataJ_q <= aluDataJ_d;
      rspData_q  <= rspData_d;
      rspEq_q    <= rspEq_d;
      rspErr_q   <= rspErr_d;
    end
  end

  assign bus.cmd_ready  = (state_q == IDLE);
  assign bus.rsp_valid  = (state_q == RESP);
  assign bus.alu_op     = aluOp;
  assign bus.alu_data_i = aluDataI_q;
  assign bus.alu_data_j = aluDataJ_q;
  assign bus.rsp_data   = rspData_q;
  assign bus.rsp_eq     = rspEq_q;
  assign bus.rsp_err    = rspErr_q;

`ifdef ALU_ISSUE_STATS_EN
  logic [15:0] statOps_q;
  logic [7:0]  statErr_q;
  logic        handoff;

  assign handoff = (state_q == RESP) && bus.rsp_ready;

  // Counters stick at all-ones rather than wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      statOps_q <= '0;
      statErr_q <= '0;
    end else if (handoff) begin
      if (!rspErr_q && (statOps_q != 16'hFFFF)) statOps_q <= statOps_q + 16'd1;
      if (rspErr_q && (statErr_q != 8'hFF))     statErr_q <= statErr_q + 8'd1;
    end
  end

  assign stat_ops = statOps_q;
  assign stat_err = statErr_q;
`endif

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Scoreboard bench for alu_issue_ctrl: one instance with EXEC_CYCLES=1, one with EXEC_CYCLES=3.
// A small ALU model drives alu_result/alu_eq; monitors pop expected responses at each handoff.
module tb_alu_issue_ctrl;

  typedef struct packed {
    logic [15:0] data;
    logic        eq;
    logic        err;
  } rsp_t;

  logic clk;
  logic rst;
  logic rst3;
  int   nCompared;
  int   nMismatched;
  int   expOpsCnt;
  int   expErrCnt;
  rsp_t q1[$];
  rsp_t q3[$];

  alu_issue_ctrl_if #(.DATA_W(16)) ifc ();
  alu_issue_ctrl_if #(.DATA_W(16)) ifc3 ();

`ifdef ALU_ISSUE_STATS_EN
  logic [15:0] statOps, statOps3;
  logic [7:0]  statErr, statErr3;
`endif

  alu_issue_ctrl #(.DATA_W(16), .EXEC_CYCLES(1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc.slave)
`ifdef ALU_ISSUE_STATS_EN
    ,
    .stat_ops (statOps),
    .stat_err (statErr)
`endif
  );

  alu_issue_ctrl #(.DATA_W(16), .EXEC_CYCLES(3)) dut3 (
    .clk (clk),
    .rst (rst3),
    .bus (ifc3.slave)
`ifdef ALU_ISSUE_STATS_EN
    ,
    .stat_ops (statOps3),
    .stat_err (statErr3)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference combinational ALU: NOT inverts operand i, CMP result is junk by design.
  function automatic logic [16:0] aluCalc(input logic [6:0] op, input logic [15:0] i, input logic [15:0] j);
    logic [15:0] res;
    case (op)
      7'b0000001: res = i;
      7'b0000010: res = i + j;
      7'b0000100: res = i - j;
      7'b0001000: res = i & j;
      7'b0010000: res = i | j;
      7'b0100000: res = ~i;
      7'b1000111: res = 16'hDEAD;
      default:    res = 16'hBEEF;
    endcase
    return {(i == j), res};
  endfunction

  assign {ifc.alu_eq, ifc.alu_result}   = aluCalc(ifc.alu_op, ifc.alu_data_i, ifc.alu_data_j);
  assign {ifc3.alu_eq, ifc3.alu_result} = aluCalc(ifc3.alu_op, ifc3.alu_data_i, ifc3.alu_data_j);

  function automatic logic [6:0] expOp(input logic [2:0] opc);
    case (opc)
      3'd0:    return 7'b0000001;
      3'd1:    return 7'b0000010;
      3'd2:    return 7'b0000100;
      3'd3:    return 7'b0001000;
      3'd4:    return 7'b0010000;
      3'd5:    return 7'b0100000;
      3'd6:    return 7'b1000111;
      default: return 7'b0000000;
    endcase
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] want);
    nCompared++;
    if (got !== want) begin
      nMismatched++;
      $display("[TB] FAIL %s: got %0h, want %0h (t=%0t)", name, got, want, $time);
    end
  endtask

  // Monitors sample just after the falling edge, when inputs for the next rising edge are settled.
  initial begin
    rsp_t e;
    forever begin
      @(negedge clk);
      #1;
      if (!rst && ifc.rsp_valid && ifc.rsp_ready) begin
        if (q1.size() == 0) begin
          checkOutput("unexpected_rsp", 32'(ifc.rsp_data), 32'hFFFF_FFFF);
        end else begin
          e = q1.pop_front();
          checkOutput("rsp_data", 32'(ifc.rsp_data), 32'(e.data));
          checkOutput("rsp_eq",   32'(ifc.rsp_eq),   32'(e.eq));
          checkOutput("rsp_err",  32'(ifc.rsp_err),  32'(e.err));
        end
      end
    end
  end

  initial begin
    rsp_t e;
    forever begin
      @(negedge clk);
      #1;
      if (!rst3 && ifc3.rsp_valid && ifc3.rsp_ready) begin
        if (q3.size() == 0) begin
          checkOutput("unexpected_rsp3", 32'(ifc3.rsp_data), 32'hFFFF_FFFF);
        end else begin
          e = q3.pop_front();
          checkOutput("rsp_data3", 32'(ifc3.rsp_data), 32'(e.data));
          checkOutput("rsp_eq3",   32'(ifc3.rsp_eq),   32'(e.eq));
          checkOutput("rsp_err3",  32'(ifc3.rsp_err),  32'(e.err));
        end
      end
    end
  end

  // Called and returns at a falling edge; the next call may issue on the very next cycle.
  task automatic applyStimulus(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                               input logic [15:0] expData, input logic expEq, input logic expErr,
                               input int holdCycles, input bit earlyReady);
    int waitCnt;
    int k;
    q1.push_back({expData, expEq, expErr});
    if (earlyReady) ifc.rsp_ready = 1'b1;
    ifc.cmd_valid  = 1'b1;
    ifc.cmd_opcode = op;
    ifc.cmd_a      = a;
    ifc.cmd_b      = b;
    waitCnt = 0;
    while (!ifc.cmd_ready && waitCnt < 20) begin
      @(negedge clk);
      waitCnt++;
    end
    checkOutput("accept_wait", 32'(waitCnt), 32'd0);
    @(negedge clk);
    ifc.cmd_valid = 1'b0;
    k = 1;
    while (!ifc.rsp_valid && k < 40) begin
      checkOutput("alu_op_exec", 32'(ifc.alu_op), 32'(expOp(op)));
      checkOutput("alu_data_i",  32'(ifc.alu_data_i), 32'(a));
      checkOutput("alu_data_j",  32'(ifc.alu_data_j), 32'(b));
      @(negedge clk);
      k++;
    end
    checkOutput("rsp_latency", 32'(k), expErr ? 32'd1 : 32'd2);
    checkOutput("alu_op_resp", 32'(ifc.alu_op), 32'd0);
    if (!earlyReady) begin
      repeat (holdCycles) begin
        checkOutput("hold_valid", 32'(ifc.rsp_valid), 32'd1);
        checkOutput("hold_cmd_ready", 32'(ifc.cmd_ready), 32'd0);
        checkOutput("hold_data", 32'(ifc.rsp_data), 32'(expData));
        @(negedge clk);
      end
      ifc.rsp_ready = 1'b1;
    end
    @(negedge clk);
    ifc.rsp_ready = 1'b0;
    checkOutput("valid_drop", 32'(ifc.rsp_valid), 32'd0);
    checkOutput("cmd_ready_after", 32'(ifc.cmd_ready), 32'd1);
    checkOutput("alu_data_i_hold", 32'(ifc.alu_data_i), 32'(a));
    if (expErr) expErrCnt++;
    else        expOpsCnt++;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int k;
    nCompared = 0;
    nMismatched = 0;
    expOpsCnt = 0;
    expErrCnt = 0;
    rst = 1'b1;
    rst3 = 1'b1;
    ifc.cmd_valid = 1'b1;
    ifc.cmd_opcode = 3'd1;
    ifc.cmd_a = 16'h1111;
    ifc.cmd_b = 16'h2222;
    ifc.rsp_ready = 1'b0;
    ifc3.cmd_valid = 1'b0;
    ifc3.cmd_opcode = 3'd0;
    ifc3.cmd_a = 16'h0;
    ifc3.cmd_b = 16'h0;
    ifc3.rsp_ready = 1'b0;

    // A command offered during reset must be ignored.
    repeat (3) @(negedge clk);
    rst = 1'b0;
    rst3 = 1'b0;
    ifc.cmd_valid = 1'b0;
    @(negedge clk);
    checkOutput("reset_cmd_ready", 32'(ifc.cmd_ready), 32'd1);
    checkOutput("reset_rsp_valid", 32'(ifc.rsp_valid), 32'd0);
    checkOutput("reset_alu_op", 32'(ifc.alu_op), 32'd0);
    checkOutput("reset_alu_data_i", 32'(ifc.alu_data_i), 32'd0);
    checkOutput("reset_alu_data_j", 32'(ifc.alu_data_j), 32'd0);
    checkOutput("reset_rsp_data", 32'(ifc.rsp_data), 32'd0);
    checkOutput("reset_rsp_err", 32'(ifc.rsp_err), 32'd0);

    applyStimulus(3'd1, 16'h0003, 16'h0004, 16'h0007, 1'b0, 1'b0, 0, 1'b0);
    applyStimulus(3'd2, 16'h0000, 16'h0001, 16'hFFFF, 1'b0, 1'b0, 0, 1'b0);
    applyStimulus(3'd5, 16'hFFFE, 16'h0000, 16'h0001, 1'b0, 1'b0, 0, 1'b0);
    applyStimulus(3'd0, 16'h5A5A, 16'h5A5A, 16'h5A5A, 1'b0, 1'b0, 0, 1'b0);
    applyStimulus(3'd3, 16'hF0F0, 16'hFF00, 16'hF000, 1'b0, 1'b0, 0, 1'b0);
    applyStimulus(3'd4, 16'hF0F0, 16'h0F00, 16'hFFF0, 1'b0, 1'b0, 0, 1'b0);
    applyStimulus(3'd6, 16'h1234, 16'h1234, 16'h0000, 1'b1, 1'b0, 0, 1'b0);
    applyStimulus(3'd6, 16'h1234, 16'h1235, 16'h0000, 1'b0, 1'b0, 0, 1'b0);
    applyStimulus(3'd7, 16'hAAAA, 16'h5555, 16'h0000, 1'b0, 1'b1, 0, 1'b0);
    applyStimulus(3'd1, 16'h1000, 16'h0234, 16'h1234, 1'b0, 1'b0, 5, 1'b0);
    applyStimulus(3'd2, 16'h0010, 16'h0001, 16'h000F, 1'b0, 1'b0, 0, 1'b0);
    applyStimulus(3'd7, 16'h0F0F, 16'h0F0F, 16'h0000, 1'b0, 1'b1, 0, 1'b1);
    applyStimulus(3'd4, 16'h0001, 16'h0002, 16'h0003, 1'b0, 1'b0, 0, 1'b1);
    checkOutput("scoreboard1_drained", 32'(q1.size()), 32'd0);

    // Three-cycle instance: full operation, alu_op must stay up for all three cycles.
    q3.push_back({16'h0030, 1'b0, 1'b0});
    ifc3.cmd_valid = 1'b1;
    ifc3.cmd_opcode = 3'd1;
    ifc3.cmd_a = 16'h0010;
    ifc3.cmd_b = 16'h0020;
    ifc3.rsp_ready = 1'b1;
    @(negedge clk);
    ifc3.cmd_valid = 1'b0;
    k = 1;
    while (!ifc3.rsp_valid && k < 40) begin
      checkOutput("alu_op_exec3", 32'(ifc3.alu_op), 32'(7'b0000010));
      @(negedge clk);
      k++;
    end
    checkOutput("rsp_latency3", 32'(k), 32'd4);
    @(negedge clk);
    ifc3.rsp_ready = 1'b0;
    checkOutput("valid_drop3", 32'(ifc3.rsp_valid), 32'd0);

    // Reset pulse in the middle of execution discards the operation.
    ifc3.cmd_valid = 1'b1;
    ifc3.cmd_opcode = 3'd2;
    ifc3.cmd_a = 16'h0005;
    ifc3.cmd_b = 16'h0003;
    @(negedge clk);
    ifc3.cmd_valid = 1'b0;
    checkOutput("alu_op_pre_rst3", 32'(ifc3.alu_op), 32'(7'b0000100));
    rst3 = 1'b1;
    @(negedge clk);
    checkOutput("rst3_alu_op", 32'(ifc3.alu_op), 32'd0);
    checkOutput("rst3_alu_data_i", 32'(ifc3.alu_data_i), 32'd0);
    checkOutput("rst3_alu_data_j", 32'(ifc3.alu_data_j), 32'd0);
    checkOutput("rst3_rsp_data", 32'(ifc3.rsp_data), 32'd0);
    checkOutput("rst3_rsp_valid", 32'(ifc3.rsp_valid), 32'd0);
    checkOutput("rst3_cmd_ready", 32'(ifc3.cmd_ready), 32'd1);
    rst3 = 1'b0;
    ifc3.rsp_ready = 1'b1;
    repeat (6) begin
      @(negedge clk);
      checkOutput("no_rsp_after_rst3", 32'(ifc3.rsp_valid), 32'd0);
    end
    ifc3.rsp_ready = 1'b0;
    checkOutput("cmd_ready_after_rst3", 32'(ifc3.cmd_ready), 32'd1);
    checkOutput("scoreboard3_drained", 32'(q3.size()), 32'd0);

`ifdef ALU_ISSUE_STATS_EN
    checkOutput("stat_ops", 32'(statOps), 32'(expOpsCnt));
    checkOutput("stat_err", 32'(statErr), 32'(expErrCnt));
    checkOutput("stat_ops3", 32'(statOps3), 32'd0);
    checkOutput("stat_err3", 32'(statErr3), 32'd0);
`endif

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
